// File: rtl/knight_rider_scanner.sv
// Bouncing-light LED scanner with run/stop button, selectable speed and pause/resume.
// Optional trailing tail LED when KR_TAIL_EN is defined.
module knight_rider_scanner #(
    parameter int NUM_LEDS = 10,
    parameter int DIV_N    = 2500000,
    parameter int PW       = $clog2(NUM_LEDS)
) (
    input  logic                CLK,
    input  logic                CLR,
    input  logic                OnOff,
    input  logic [1:0]          SPEED,
    output logic [NUM_LEDS-1:0] LEDR,
    output logic [PW-1:0]       POS,
    output logic                DIR,
    output logic                RUN
);

    typedef enum logic [1:0] {
        S_STOP,
        S_UP,
        S_DOWN
    } state_t;

    localparam logic [NUM_LEDS-1:0] ONE  = NUM_LEDS'(1);
    localparam logic [PW-1:0]       LAST = PW'(NUM_LEDS - 1);

    state_t              r_state;
    state_t              w_state_next;
    logic [PW-1:0]       r_pos;
    logic [PW-1:0]       w_pos_next;
    logic                r_dir;
    logic                w_dir_next;
    logic                r_run;
    logic                w_run_next;
    logic                w_resume;
    logic                w_press;
    logic                w_step;
    logic                w_wrap;
    logic                r_sync1;
    logic                r_sync2;
    logic                r_btn_prev;
    logic [31:0]         r_cnt;
    logic [31:0]         r_term;
    logic [31:0]         w_term_new;
    logic [NUM_LEDS-1:0] r_led;
    logic [NUM_LEDS-1:0] w_led_next;
    logic [NUM_LEDS-1:0] w_tail_mask;

    // Synchronise the button and keep its previous value for edge detection
    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            r_sync1    <= 1'b1;
            r_sync2    <= 1'b1;
            r_btn_prev <= 1'b1;
        end else begin
            r_sync1    <= OnOff;
            r_sync2    <= r_sync1;
            r_btn_prev <= r_sync2;
        end
    end

    assign w_press    = ~r_sync2 & r_btn_prev;
    assign w_term_new = (32'(DIV_N) << SPEED) - 32'd1;
    assign w_wrap     = r_run && (r_cnt == r_term);
    // A press on a wrap edge stops the scanner and drops the step
    assign w_step     = w_wrap && !w_press;

    // Step prescaler; terminal count reloads only on resume or wrap
    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            r_cnt  <= 32'd0;
            r_term <= 32'(DIV_N) - 32'd1;
        end else if (w_resume) begin
            r_cnt  <= 32'd0;
            r_term <= w_term_new;
        end else if (!w_run_next) begin
            r_cnt  <= 32'd0;
        end else if (w_wrap) begin
            r_cnt  <= 32'd0;
            r_term <= w_term_new;
        end else begin
            r_cnt  <= r_cnt + 32'd1;
        end
    end

    // Next state, position and direction
    always_comb begin
        w_state_next = r_state;
        w_pos_next   = r_pos;
        w_dir_next   = r_dir;
        w_resume     = 1'b0;
        unique case (r_state)
            S_STOP: begin
                if (w_press) begin
                    w_state_next = r_dir ? S_DOWN : S_UP;
                    w_resume     = 1'b1;
                end
            end
            S_UP: begin
                if (w_press) begin
                    w_state_next = S_STOP;
                end else if (w_step) begin
                    w_pos_next = r_pos + PW'(1);
                    if (w_pos_next == LAST) begin
                        w_state_next = S_DOWN;
                        w_dir_next   = 1'b1;
                    end
                end
            end
            S_DOWN: begin
                if (w_press) begin
                    w_state_next = S_STOP;
                end else if (w_step) begin
                    w_pos_next = r_pos - PW'(1);
                    if (w_pos_next == '0) begin
                        w_state_next = S_UP;
                        w_dir_next   = 1'b0;
                    end
                end
            end
            default: begin
                w_state_next = S_STOP;
            end
        endcase
    end

    assign w_run_next = (w_state_next != S_STOP);

`ifdef KR_TAIL_EN
    logic [PW-1:0] r_tail_pos;
    logic [PW-1:0] w_tail_pos_next;
    logic          r_tail_vld;
    logic          w_tail_vld_next;

    // Tail remembers the position vacated by the last step
    always_comb begin
        w_tail_pos_next = r_tail_pos;
        w_tail_vld_next = r_tail_vld;
        if (w_resume) begin
            w_tail_vld_next = 1'b0;
        end else if (w_step) begin
            w_tail_pos_next = r_pos;
            w_tail_vld_next = 1'b1;
        end
    end

    // Tail register
    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            r_tail_pos <= '0;
            r_tail_vld <= 1'b0;
        end else begin
            r_tail_pos <= w_tail_pos_next;
            r_tail_vld <= w_tail_vld_next;
        end
    end

    assign w_tail_mask = w_tail_vld_next ? (ONE << w_tail_pos_next) : '0;
`else
    assign w_tail_mask = '0;
`endif

    // LED pattern follows the next position so it changes with POS
    always_comb begin
        w_led_next = '0;
        if (w_run_next) begin
            w_led_next = (ONE << w_pos_next) | w_tail_mask;
        end
    end

    // State and output registers
    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            r_state <= S_STOP;
            r_pos   <= '0;
            r_dir   <= 1'b0;
            r_run   <= 1'b0;
            r_led   <= '0;
        end else begin
            r_state <= w_state_next;
            r_pos   <= w_pos_next;
            r_dir   <= w_dir_next;
            r_run   <= w_run_next;
            r_led   <= w_led_next;
        end
    end

    assign LEDR = r_led;
    assign POS  = r_pos;
    assign DIR  = r_dir;
    assign RUN  = r_run;

endmodule

// File: doc/knight_rider_scanner.md
# knight_rider_scanner

Parametrised bouncing-light scanner driving a bank of NUM_LEDS outputs for the DE1-SoC LED bar. It combines a run/stop toggle from a normally-high push button, a programmable prescaler from CLOCK_50, and an up/down position state machine. The block reverses at each end with no skipped or doubled endpoint. It replaces the fixed 10-LED, fixed-rate flasher and adds selectable speed, pause/resume and an optional trailing tail.

## Interface
Parameters:
- NUM_LEDS, 10, number of LED outputs; must be >= 2.
- DIV_N, 2500000, base prescaler period in CLK cycles per step; must be >= 2.
- PW, $clog2(NUM_LEDS), width of POS; derived, not overridden.

Ports:
- CLK  in  1  system clock (CLOCK_50); all logic on its rising edge.
- CLR  in  1  asynchronous, active-high reset.
- OnOff  in  1  push button, normally high; each press (high->low) toggles run/stop.
- SPEED  in  2  step period = DIV_N << SPEED cycles (x1, x2, x4, x8).
- LEDR  out  NUM_LEDS  LED drive, registered.
- POS  out  PW  current lit position, 0 = LEDR[0].
- DIR  out  1  0 = moving up (toward LEDR[NUM_LEDS-1]), 1 = moving down.
- RUN  out  1  1 while scanning.

## Operation
- **Button path.** OnOff is synchronised through 2 flops, then a third flop holds the previous value. A press is sync == 0 while prev == 1, and it toggles RUN. The button is debounced externally.
- **Prescaler.** Counter cnt is 32 bits wide, with terminal T = (DIV_N << SPEED) - 1.
  - While RUN = 1: cnt increments. When cnt == T it returns to 0 and the step event fires on that edge.
  - SPEED is sampled only when cnt wraps or RUN rises.
  - While RUN = 0: cnt is held at 0.
- **State machine.** States are STOP, UP and DOWN; DIR = 1 only in DOWN, and STOP keeps the last direction.
  - UP + step: POS <= POS+1. If the new POS == NUM_LEDS-1, go to DOWN.
  - DOWN + step: POS <= POS-1. If the new POS == 0, go to UP.
  - The sequence for NUM_LEDS = 10 is 0,1,…,9,8,…,1,0,1,… with a period of 2*(NUM_LEDS-1) steps. Each endpoint is shown for exactly one step period.
  - Press while running: go to STOP. POS and direction are held, and LEDR is forced to all zeros.
  - Press in STOP: resume in the held direction from the held POS. cnt restarts from 0, so the first step comes a full period after resume.
- **LEDR.** While running, LEDR = one-hot(POS), registered and updated on the same edge as POS.
- **Reset.** CLR = 1 gives: POS = 0, direction UP, RUN = 0, DIR = 0, LEDR = 0, cnt = 0, all button sync flops = 1. This applies mid-scan as well; the next RUN starts from LED 0 moving up.
- **Boundary cases.**
  - A press on the same edge as a step: the stop wins and the step is discarded.
  - A SPEED change mid-period takes effect at the next wrap.

## Timing
- A press reaches RUN 3 CLK edges after OnOff falls (2 sync edges + 1 edge-detect edge).
- Step latency: POS, LEDR and DIR change on the edge where cnt == T, with no further pipeline.
- After RUN rises, LEDR shows one-hot(POS) on the next edge, and the first step follows DIN_N << SPEED cycles after RUN rises.
- All outputs are glitch-free register outputs.

## Configuration
- KR_TAIL_EN defined:
  - A register prev holds the position vacated by the last step; prev is invalid after reset and after resume.
  - LEDR = one-hot(POS) | one-hot(prev) while prev is valid, so two adjacent LEDs are lit.
  - At a reversal, prev is the endpoint just left (e.g. POS = 8, prev = 9).
  - STOP clears LEDR as normal.
- KR_TAIL_EN undefined: there is no prev register, and LEDR is strictly one-hot or zero.

## Test plan
All scenarios use DIV_N = 4, NUM_LEDS = 10, SPEED = 0 unless stated.
- Reset: CLR pulse mid-scan -> LEDR = 0, POS = 0, DIR = 0, RUN = 0 immediately and asynchronously.
- Full sweep: one press, run 80 cycles -> POS steps every 4 cycles through 0..9..0. DIR goes 1 at POS = 9 and 0 at POS = 0, and neither endpoint is repeated.
- Pause/resume: press at POS = 6 while DOWN -> LEDR = 0 and POS = 6 held. Press again -> LEDR = 0x040, first step 4 cycles later to POS = 5.
- Speed: SPEED = 3 -> step every 32 cycles. Change to 1 mid-period -> 32-cycle period completes, then 8-cycle steps.
- Collision: press asserted on the edge where cnt == T -> RUN = 0, POS unchanged.
- KR_TAIL_EN: at the reversal, LEDR = 0x300 then 0x180, and after resume only one LED is lit until the first step.
